// File: rtl/noise_rand_source.sv
// noise_rand_source: four 32-bit Galois LFSRs with seed loading, warm-up and run control.
// Outputs decode straight from the state and LFSR registers, so inputs never reach them combinationally.
module noise_rand_source #(
    parameter int          RAND_OUT_BITS = 10,
    parameter int          WARMUP_CYCLES = 64,
    parameter logic [31:0] SEED0         = 32'h1234_5678,
    parameter logic [31:0] SEED1         = 32'h9ABC_DEF1,
    parameter logic [31:0] SEED2         = 32'h0F1E_2D3C,
    parameter logic [31:0] SEED3         = 32'hDEAD_BEEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     seed_wr,
    input  logic [1:0]               seed_addr,
    input  logic [31:0]              seed_data,
    input  logic                     start,
    input  logic                     stop,
    output logic [RAND_OUT_BITS-1:0] rand0,
    output logic [RAND_OUT_BITS-1:0] rand1,
    output logic [RAND_OUT_BITS-1:0] rand2,
    output logic                     rand3,
    output logic                     rand_valid,
    output logic                     busy,
    output logic                     seed_err
);
    typedef enum logic [1:0] {IDLE, WARMUP, RUN} state_t;
    localparam int CW = WARMUP_CYCLES > 1 ? $clog2(WARMUP_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(WARMUP_CYCLES > 0 ? WARMUP_CYCLES - 1 : 0);
    localparam logic [31:0] SEEDS [4] = '{SEED0, SEED1, SEED2, SEED3};
    state_t state, state_nxt;
    logic [CW-1:0] cnt;
    logic [31:0] lfsr [4];
    logic step, load;
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction
    assign step = state != IDLE && !stop;
    assign load = state == IDLE && seed_wr;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start && !stop ? (WARMUP_CYCLES == 0 ? RUN : WARMUP) : IDLE;
            WARMUP:  state_nxt = stop ? IDLE : (cnt == LAST ? RUN : WARMUP);
            RUN:     state_nxt = stop ? IDLE : RUN;
            default: state_nxt = IDLE;
        endcase
    end
    // A zero seed would lock the LFSR, so it falls back to the reset seed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            seed_err <= 1'b0;
            for (int k = 0; k < 4; k++) lfsr[k] <= SEEDS[k];
        end else begin
            state    <= state_nxt;
            cnt      <= state == WARMUP && step && cnt != LAST ? cnt + 1'b1 : '0;
            seed_err <= seed_wr && state != IDLE;
            for (int k = 0; k < 4; k++)
                lfsr[k] <= step ? lfsr_step(lfsr[k]) :
                           load && seed_addr == 2'(k) ? (seed_data == 32'h0 ? SEEDS[k] : seed_data) :
                           lfsr[k];
        end
    end
    assign rand0      = lfsr[0][RAND_OUT_BITS-1:0];
    assign rand1      = lfsr[1][RAND_OUT_BITS-1:0];
    assign rand2      = lfsr[2][RAND_OUT_BITS-1:0];
    assign rand3      = lfsr[3][0];
    assign rand_valid = state == RUN;
    assign busy       = state != IDLE;
endmodule

// File: tb/tb_noise_rand_source.sv
// tb_noise_rand_source: three instances (warm-up 1, 0, 4) on shared stimulus, checked
// against hand-computed vectors and an LFSR step model.
module tb_noise_rand_source;
    localparam logic [31:0] SD [4] = '{32'h1234_5678, 32'h9ABC_DEF1, 32'h0F1E_2D3C, 32'hDEAD_BEEF};
    localparam int WC [3] = '{1, 0, 4};
    typedef struct {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] data;
        logic        st;
        logic        sp;
        logic        v;
        logic        b;
        logic        e;
        logic [9:0]  r;
    } vec_t;
    logic clk = 1'b0, rst = 1'b0, seed_wr = 1'b0, start = 1'b0, stop = 1'b0;
    logic [1:0] seed_addr = 2'd0;
    logic [31:0] seed_data = 32'd0;
    logic [9:0] r0 [3], r1 [3], r2 [3];
    logic r3 [3], rv [3], bz [3], se [3];
    logic [31:0] m [3][4];
    int checks = 0, failures = 0;
    vec_t tbl [15];
    always #5 clk = ~clk;
    for (genvar g = 0; g < 3; g++) begin : g_dut
        noise_rand_source #(.WARMUP_CYCLES(g == 0 ? 1 : g == 1 ? 0 : 4)) u (
            .clk(clk), .rst(rst), .seed_wr(seed_wr), .seed_addr(seed_addr), .seed_data(seed_data),
            .start(start), .stop(stop), .rand0(r0[g]), .rand1(r1[g]), .rand2(r2[g]), .rand3(r3[g]),
            .rand_valid(rv[g]), .busy(bz[g]), .seed_err(se[g]));
    end
    function automatic logic [31:0] nxt(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk_dut(input int d, input int j, input logic v, input logic b, input logic e);
        chk($sformatf("d%0d j%0d rand0", d, j), 32'(r0[d]), 32'(m[d][0][9:0]));
        chk($sformatf("d%0d j%0d rand1", d, j), 32'(r1[d]), 32'(m[d][1][9:0]));
        chk($sformatf("d%0d j%0d rand2", d, j), 32'(r2[d]), 32'(m[d][2][9:0]));
        chk($sformatf("d%0d j%0d rand3", d, j), 32'(r3[d]), 32'(m[d][3][0]));
        chk($sformatf("d%0d j%0d rand_valid", d, j), 32'(rv[d]), 32'(v));
        chk($sformatf("d%0d j%0d busy", d, j), 32'(bz[d]), 32'(b));
        chk($sformatf("d%0d j%0d seed_err", d, j), 32'(se[d]), 32'(e));
    endtask
    task automatic seed_model;
        for (int d = 0; d < 3; d++) for (int k = 0; k < 4; k++) m[d][k] = SD[k];
    endtask
    // Start, then n cycles; a rejected seed write is injected on cycle wr_at.
    task automatic run_seq(input int n, input int wr_at);
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int d = 0; d < 3; d++) chk_dut(d, 0, WC[d] == 0, 1'b1, 1'b0);
        for (int j = 1; j <= n; j++) begin
            if (j == wr_at) begin
                seed_wr = 1'b1; seed_addr = 2'd1; seed_data = 32'h0000_FFFF;
            end
            tick;
            seed_wr = 1'b0;
            for (int d = 0; d < 3; d++) for (int k = 0; k < 4; k++) m[d][k] = nxt(m[d][k]);
            for (int d = 0; d < 3; d++) chk_dut(d, j, j >= WC[d], 1'b1, j == wr_at);
        end
    endtask
    task automatic stop_chk;
        stop = 1'b1;
        tick;
        stop = 1'b0;
        for (int d = 0; d < 3; d++) chk_dut(d, -1, 1'b0, 1'b0, 1'b0);
    endtask
    initial begin
        tbl = '{
            '{1'b1, 2'd0, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h001},
            '{1'b0, 2'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'h001},
            '{1'b0, 2'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'h003},
            '{1'b0, 2'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'h002},
            '{1'b0, 2'd0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'h001},
            '{1'b1, 2'd0, 32'd5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'h003},
            '{1'b0, 2'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'h002},
            '{1'b0, 2'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'h002},
            '{1'b0, 2'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h002},
            '{1'b0, 2'd0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'h002},
            '{1'b1, 2'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h278},
            '{1'b1, 2'd0, 32'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'h001},
            '{1'b0, 2'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'h001},
            '{1'b0, 2'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'h001},
            '{1'b0, 2'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'h003}
        };
        #2 rst = 1'b1;
        tick;
        seed_model;
        for (int d = 0; d < 3; d++) chk_dut(d, -1, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            seed_wr = tbl[i].wr; seed_addr = tbl[i].addr; seed_data = tbl[i].data;
            start = tbl[i].st; stop = tbl[i].sp;
            tick;
            seed_wr = 1'b0; start = 1'b0; stop = 1'b0;
            chk($sformatf("vec%0d rand0", i), 32'(r0[0]), 32'(tbl[i].r));
            chk($sformatf("vec%0d rand_valid", i), 32'(rv[0]), 32'(tbl[i].v));
            chk($sformatf("vec%0d busy", i), 32'(bz[0]), 32'(tbl[i].b));
            chk($sformatf("vec%0d seed_err", i), 32'(se[0]), 32'(tbl[i].e));
        end
        // Asynchronous reset in the middle of a clock period while running.
        #2 rst = 1'b1;
        #1;
        seed_model;
        for (int d = 0; d < 3; d++) chk_dut(d, -2, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        seed_wr = 1'b1; seed_addr = 2'd3; seed_data = 32'h54;
        tick;
        chk("seed3 0x54 rand3", 32'(r3[0]), 32'd0);
        seed_data = 32'h0;
        tick;
        seed_wr = 1'b0;
        for (int d = 0; d < 3; d++) chk_dut(d, -3, 1'b0, 1'b0, 1'b0);
        run_seq(12, 6);
        stop_chk;
        run_seq(2, -1);
        stop_chk;
        run_seq(6, -1);
        stop_chk;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
